// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter and load/shift sequencer for one shared PISO shift register.
// Words are granted with a one-cycle ready pulse, loaded, then shifted out with per-bit flags.
module piso_tx_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int GW = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  hold,
  output logic                  piso_enable,
  output logic                  piso_select,
  output logic [WIDTH-1:0]      piso_data,
  output logic                  bit_valid,
  output logic [CW-1:0]         bit_index,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  // Handshake: a requester raises req_valid with stable req_data and keeps both
  // until it sees req_ready; the word is accepted on the clock edge ending that cycle.

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic [WIDTH-1:0]  word_q, word_d;

  logic              win_found;
  logic [GW-1:0]     win_idx;
  int                cand;
  logic              last_bit;
  logic              grant_opp;
  logic              grant;

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid[GW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  assign last_bit  = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1)) && !hold;
  assign grant_opp = !reset && ((state_q == S_IDLE) || last_bit);
  assign grant     = grant_opp && win_found;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    word_d  = word_q;
    if (grant) begin
      ptr_d  = win_idx;
      gid_d  = win_idx;
      word_d = req_data[int'(win_idx)*WIDTH +: WIDTH];
    end
    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (!hold) begin
          if (last_bit) begin
            state_d = grant ? S_LOAD : S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= GW'(NREQ - 1);
      gid_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      word_q  <= word_d;
    end
  end

  // Outputs decode state and count; hold only masks the shift enable and bit flag.
  assign req_ready   = grant ? (NREQ'(1) << win_idx) : '0;
  assign piso_enable = (state_q == S_LOAD) || ((state_q == S_SHIFT) && !hold);
  assign piso_select = (state_q == S_SHIFT);
  assign piso_data   = (state_q == S_LOAD) ? word_q : '0;
  assign bit_valid   = (state_q == S_SHIFT) && !hold;
  assign bit_index   = bit_valid ? cnt_q : '0;
  assign grant_id    = gid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = last_bit;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: scoreboarded grants and serial bits on a 2x4 instance,
// plus directed checks on a 4x8 instance.
module tb_piso_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_data;
  logic [1:0] req_ready;
  logic       hold;
  logic       piso_enable, piso_select, bit_valid, busy, done;
  logic [3:0] piso_data;
  logic [1:0] bit_index;
  logic       grant_id;

  logic        rst5;
  logic [3:0]  rv5, rr5;
  logic [31:0] rd5;
  logic        pe5, ps5, bv5, busy5, done5;
  logic [7:0]  pd5;
  logic [2:0]  bi5;
  logic [1:0]  gid5;

  piso_tx_arbiter #(.WIDTH(4), .NREQ(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hold(hold), .piso_enable(piso_enable),
    .piso_select(piso_select), .piso_data(piso_data), .bit_valid(bit_valid),
    .bit_index(bit_index), .grant_id(grant_id), .busy(busy), .done(done)
  );

  piso_tx_arbiter #(.WIDTH(8), .NREQ(4)) dut5 (
    .clk(clk), .reset(rst5), .req_valid(rv5), .req_data(rd5),
    .req_ready(rr5), .hold(1'b0), .piso_enable(pe5),
    .piso_select(ps5), .piso_data(pd5), .bit_valid(bv5),
    .bit_index(bi5), .grant_id(gid5), .busy(busy5), .done(done5)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PISO model, MSB shifted out first; contents survive reset
  logic [3:0] sr = 4'b0;
  always @(posedge clk) begin
    if (piso_enable) sr <= piso_select ? {sr[2:0], 1'b0} : piso_data;
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] grant_q[$];
  logic [4:0] exp_q[$];
  int         gcyc_q[$];
  int         last_done  = 0;
  int         first_bit  = 0;
  logic       load_pend  = 1'b0;
  logic [3:0] load_data  = 4'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_word(input logic [1:0] who, input logic [3:0] data,
                           input logic gid, input int nbits);
    logic [3:0] d;
    d = data;
    grant_q.push_back({who, data});
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back({gid, 2'(i), (i == 3), d[3]});
      d = d << 1;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [5:0] g;
    logic [4:0] e;
    if (reset) begin
      load_pend = 1'b0;
    end else begin
      if (load_pend) begin
        check("load_ctl", {29'b0, piso_enable, piso_select, busy}, 32'b101);
        check("load_data", {28'b0, piso_data}, {28'b0, load_data});
        load_pend = 1'b0;
      end
      if (req_ready != 2'b00) begin
        check("ready_onehot", {31'b0, $onehot(req_ready)}, 32'd1);
        if (grant_q.size() == 0) begin
          check("unexpected_grant", {30'b0, req_ready}, 32'd0);
        end else begin
          g = grant_q.pop_front();
          check("grant_ready", {30'b0, req_ready}, {30'b0, g[5:4]});
          load_data = g[3:0];
          load_pend = 1'b1;
        end
        gcyc_q.push_back(cyc);
      end
      if (bit_valid) begin
        if (bit_index == 2'd0) first_bit = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", {30'b0, bit_index}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("bit", {27'b0, grant_id, bit_index, done, sr[3]}, {27'b0, e});
        end
      end else if (done) begin
        check("done_without_bit", {31'b0, done}, 32'd0);
      end
      if (done) last_done = cyc;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic [1:0] seen);
    seen = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        seen = req_ready;
        break;
      end
    end
    if (seen == 2'b00) check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bit(input logic [1:0] idx);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bit_valid && bit_index == idx) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("wait_bit_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_idle();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] outs_a();
    return {18'b0, req_ready, piso_enable, piso_select, piso_data,
            bit_valid, bit_index, grant_id, busy, done};
  endfunction

  initial begin
    logic [1:0] s;
    reset = 1'b1; req_valid = 2'b00; req_data = 8'h00; hold = 1'b0;
    rst5 = 1'b1; rv5 = 4'b0; rd5 = 32'b0;

    // scenario 1: reset, single word from requester 0
    tick(); tick();
    @(negedge clk);
    check("s1_reset_outputs", outs_a(), 32'd0);
    tick();
    reset = 1'b0; req_valid = 2'b01; req_data = 8'h0B;
    gcyc_q.delete();
    push_word(2'b01, 4'b1011, 1'b0, 4);
    wait_ready(s); tick(); req_valid &= ~s;
    wait_idle();
    check("s1_done_latency", 32'(last_done - gcyc_q[0]), 32'd5);
    check("s1_first_bit_latency", 32'(first_bit - gcyc_q[0]), 32'd2);
    check("s1_idle_outputs", outs_a() & ~32'h2, 32'd0);

    // scenario 2: both requesters continuously valid
    tick(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    req_valid = 2'b11; req_data = 8'h5C;
    gcyc_q.delete();
    push_word(2'b01, 4'hC, 1'b0, 4);
    push_word(2'b10, 4'h5, 1'b1, 4);
    push_word(2'b01, 4'hC, 1'b0, 4);
    push_word(2'b10, 4'h5, 1'b1, 4);
    for (int k = 0; k < 3; k++) wait_ready(s);
    wait_ready(s); tick(); req_valid = 2'b00;
    wait_idle();
    check("s2_grant_count", 32'(gcyc_q.size()), 32'd4);
    for (int k = 1; k < 4 && k < gcyc_q.size(); k++)
      check("s2_cadence", 32'(gcyc_q[k] - gcyc_q[k-1]), 32'd5);

    // scenario 3: hold for 3 cycles after bit 1
    tick();
    req_valid = 2'b01; req_data = 8'h0B;
    gcyc_q.delete();
    push_word(2'b01, 4'b1011, 1'b0, 4);
    wait_ready(s); tick(); req_valid &= ~s;
    wait_bit(2'd1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("s3_hold_ctl", {28'b0, bit_valid, piso_enable, piso_select, busy}, 32'b0011);
      tick();
    end
    hold = 1'b0;
    wait_idle();
    check("s3_done_latency", 32'(last_done - gcyc_q[0]), 32'd8);

    // scenario 4: reset in the middle of a word, then pointer restarts at 0
    tick();
    req_valid = 2'b01; req_data = 8'h0E;
    push_word(2'b01, 4'hE, 1'b0, 2);
    wait_ready(s); tick(); req_valid &= ~s;
    wait_bit(2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("s4_post_reset_outputs", outs_a(), 32'd0);
    tick();
    req_valid = 2'b11; req_data = 8'h96;
    push_word(2'b01, 4'h6, 1'b0, 4);
    push_word(2'b10, 4'h9, 1'b1, 4);
    wait_ready(s); tick(); req_valid &= ~s;
    wait_ready(s); tick(); req_valid &= ~s;
    wait_idle();

    // scenario 6: requester 1 withdraws while requester 0 is serializing
    tick();
    req_valid = 2'b11; req_data = 8'h3B;
    push_word(2'b01, 4'hB, 1'b0, 4);
    wait_ready(s); tick(); req_valid &= ~s;
    wait_bit(2'd1);
    req_valid = 2'b00;
    wait_idle();
    tick(); tick(); tick();
    @(negedge clk);
    check("s6_stays_idle", {30'b0, busy, req_ready != 2'b00}, 32'd0);

    // scenario 5: wide instance, only requester 3
    tick();
    rst5 = 1'b0; rv5 = 4'b1000; rd5 = 32'hA500_0000;
    @(negedge clk);
    check("s5_ready", {28'b0, rr5}, 32'b1000);
    tick(); rv5 = 4'b0;
    @(negedge clk);
    check("s5_load", {21'b0, pe5, ps5, busy5, pd5}, {21'b0, 3'b101, 8'hA5});
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      check("s5_bit", {25'b0, bv5, bi5, gid5, done5},
            {25'b0, 1'b1, 3'(k), 2'd3, (k == 7)});
    end
    tick();
    @(negedge clk);
    check("s5_idle", {30'b0, busy5, bv5}, 32'd0);

    check("grant_queue_drained", 32'(grant_q.size()), 32'd0);
    check("bit_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
